// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the UART transmit path.
//   tx_state_t           - serializer FSM states
//   DEFAULT_CLKS_PER_BIT - 100 MHz clock at 115200 baud
//   UART_FRAME_BITS      - start + 8 data + stop
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_FRAME_BITS      = 10;

endpackage

// File: rtl/serial_fifo.sv
// serial_fifo: byte FIFO with show-ahead read port.
//   clock, reset : clock and asynchronous active-high reset
//   push, din    : write strobe and byte (ignored while full)
//   pop, dout    : read strobe (ignored while empty); dout is the current head
//   level        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module serial_fifo #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [PTR_W:0]   level,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two; the count is
  // kept separately so full and empty are unambiguous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = count_q;
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/serial_uart_tx.sv
// serial_uart_tx: buffers bytes from the processor serial write port and sends
// each one as an 8N1 UART frame (LSB first).
//   clock, reset : clock and asynchronous active-high reset
//   wr_data      : byte from processor serial_out
//   wr_en        : write strobe from processor serial_wren_out
//   ready        : FIFO not full (to processor serial_ready_in)
//   tx           : UART line, idle high, registered
//   busy         : frame in progress or bytes still queued
//   overflow     : sticky, set by a write attempted while full
//   level        : FIFO occupancy 0..DEPTH
module serial_uart_tx
  import serial_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int DEPTH        = 8,
  localparam int PTR_W        = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             overflow,
  output logic [PTR_W:0]   level
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // Frame is start + data + stop, so the data bits are indices 0..FRAME-3.
  localparam logic [2:0]      LAST_BIT  = 3'(UART_FRAME_BITS - 3);

  tx_state_t         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        sh_q;
  logic              tx_q;
  logic              overflow_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic [PTR_W:0]    fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              bit_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign fifo_push = wr_en && !fifo_full;
  // The next frame is fetched either from idle or straight out of the stop
  // bit, which gives back-to-back frames with no idle gap.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  serial_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            sh_q    <= fifo_dout;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (fifo_pop) begin
              sh_q    <= fifo_dout;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (wr_en && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign ready    = !fifo_full;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign overflow = overflow_q;
  assign level    = fifo_level;

endmodule

// File: tb/tb_serial_uart_tx.sv
// tb_serial_uart_tx: self-checking bench for serial_uart_tx with CLKS_PER_BIT=4
// and DEPTH=4. A frame-timeline model (queue of pending bytes plus the byte
// on the line and its elapsed cycle count) predicts every output each cycle;
// an independent line receiver decodes tx back into bytes.
module tb_serial_uart_tx;
  import serial_pkg::*;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = UART_FRAME_BITS * C;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  serial_uart_tx #(
    .CLKS_PER_BIT (C),
    .DEPTH        (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .ready    (ready),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clock = ~clock;

  // Behavioural model: pending queue, byte currently on the line and the
  // number of cycles since its start bit began.
  logic [7:0] mQ[$];
  logic [7:0] mTxLog[$];
  logic [7:0] mCur = 8'h00;
  bit         mActive = 1'b0;
  int         mT = 0;
  bit         mOverflow = 1'b0;
  bit         mAccept;
  bit         mStart;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      mQ.delete();
      mActive   = 1'b0;
      mT        = 0;
      mOverflow = 1'b0;
    end else begin
      mAccept = wr_en && (mQ.size() < DEPTH);
      if (wr_en && !mAccept) mOverflow = 1'b1;
      mStart = (!mActive || (mT == FRAME - 1)) && (mQ.size() > 0);
      if (mActive) begin
        if (mT == FRAME - 1) mActive = 1'b0;
        else                 mT = mT + 1;
      end
      if (mStart) begin
        mCur    = mQ.pop_front();
        mTxLog.push_back(mCur);
        mActive = 1'b1;
        mT      = 0;
      end
      if (mAccept) mQ.push_back(wr_data);
    end
  end

  function automatic logic expTx();
    int idx;
    if (!mActive) return 1'b1;
    idx = mT / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return mCur[idx-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    if (checkEn) begin
      checkOutput("tx",       32'(tx),       32'(expTx()));
      checkOutput("level",    32'(level),    32'(mQ.size()));
      checkOutput("ready",    32'(ready),    32'(mQ.size() != DEPTH));
      checkOutput("busy",     32'(busy),     32'(mActive || (mQ.size() != 0)));
      checkOutput("overflow", 32'(overflow), 32'(mOverflow));
    end
  end

  // Line receiver: samples each bit mid-period after the detected start edge.
  logic [7:0] rxQ[$];
  logic [7:0] rxByte = 8'h00;
  bit         rxBusy = 1'b0;
  int         rxCnt  = 0;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      rxBusy = 1'b0;
    end else if (!rxBusy) begin
      if (tx === 1'b0) begin
        rxBusy = 1'b1;
        rxCnt  = 0;
      end
    end else begin
      rxCnt = rxCnt + 1;
      for (int i = 1; i <= 8; i++) begin
        if (rxCnt == C * i + C / 2) rxByte[i-1] = tx;
      end
      if (rxCnt == 9 * C + C / 2) begin
        rxQ.push_back(rxByte);
        rxBusy = 1'b0;
      end
    end
  end

  // One clock cycle: drive at a falling edge, return at the next falling edge.
  task automatic applyStimulus(input logic en, input logic [7:0] d);
    wr_en   = en;
    wr_data = d;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_tx",    32'(tx),       32'd1);
    checkOutput("rst_ready", 32'(ready),    32'd1);
    checkOutput("rst_busy",  32'(busy),     32'd0);
    checkOutput("rst_ovf",   32'(overflow), 32'd0);
    checkOutput("rst_level", 32'(level),    32'd0);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic waitIdle(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!mActive && (mQ.size() == 0)) begin
        done = 1'b1;
        break;
      end
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("drain_timeout", 32'(done), 32'd1);
    repeat (2) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic checkRx(input string name, input logic [7:0] exp[$]);
    checkOutput({name, "_count"}, 32'(rxQ.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rxQ.size(); i++) begin
      checkOutput(name, 32'(rxQ[i]), 32'(exp[i]));
    end
  endtask

  logic [9:0] pat;
  bit         found;
  int         pct;

  initial begin
    doReset();
    checkEn = 1'b1;

    // Single byte 0x41: start at k+1, 10 bits of 4 cycles, idle at k+41.
    pat = 10'b1010000010;
    rxQ.delete();
    applyStimulus(1'b1, 8'h41);
    checkOutput("t1_tx_k", 32'(tx), 32'd1);
    checkOutput("t1_level_k", 32'(level), 32'd1);
    for (int c = 1; c <= 41; c++) begin
      applyStimulus(1'b0, 8'h00);
      if (c == 1) checkOutput("t1_fall", 32'(tx), 32'd0);
      if ((c >= 3) && ((c - 3) % C == 0) && ((c - 3) / C < 10))
        checkOutput("t1_bit", 32'(tx), 32'(pat[(c - 3) / C]));
      if (c == 40) checkOutput("t1_busy40", 32'(busy), 32'd1);
      if (c == 41) begin
        checkOutput("t1_busy41", 32'(busy), 32'd0);
        checkOutput("t1_idle41", 32'(tx), 32'd1);
      end
    end
    checkRx("t1_rx", '{8'h41});

    // Back-to-back 0x55, 0xAA: second start bit immediately follows stop bit.
    rxQ.delete();
    applyStimulus(1'b1, 8'h55);
    checkOutput("t2_level_k", 32'(level), 32'd1);
    applyStimulus(1'b1, 8'hAA);
    checkOutput("t2_level_k1", 32'(level), 32'd1);
    for (int c = 2; c <= 41; c++) begin
      applyStimulus(1'b0, 8'h00);
      if (c == 40) checkOutput("t2_stop", 32'(tx), 32'd1);
      if (c == 41) begin
        checkOutput("t2_nogap", 32'(tx), 32'd0);
        checkOutput("t2_level41", 32'(level), 32'd0);
      end
    end
    waitIdle(200);
    checkRx("t2_rx", '{8'h55, 8'hAA});

    // Push coinciding with the pop at the end of a stop bit.
    rxQ.delete();
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b1, 8'h99);
    for (int c = 2; c <= 40; c++) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h7E);
    checkOutput("t4_level", 32'(level), 32'd1);
    checkOutput("t4_start", 32'(tx), 32'd0);
    waitIdle(300);
    checkRx("t4_rx", '{8'h3C, 8'h99, 8'h7E});

    // Fill while busy, then overflow with the fifth byte.
    rxQ.delete();
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (i == 4) begin
        checkOutput("t3_ready", 32'(ready), 32'd0);
        checkOutput("t3_ovf0", 32'(overflow), 32'd0);
      end
      if (i == 5) begin
        checkOutput("t3_ovf1", 32'(overflow), 32'd1);
        checkOutput("t3_level", 32'(level), 32'd4);
      end
    end
    waitIdle(400);
    checkOutput("t3_sticky", 32'(overflow), 32'd1);
    checkRx("t3_rx", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04});

    // Reset during data bit 3 of 0xC3 with two bytes queued.
    rxQ.delete();
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mActive && (mCur == 8'hC3) && (mT / C == 4)) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("t5_reach_timeout", 32'(found), 32'd1);
    checkOutput("t5_pre_level", 32'(level), 32'd2);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5_tx",    32'(tx),       32'd1);
    checkOutput("t5_level", 32'(level),    32'd0);
    checkOutput("t5_ready", 32'(ready),    32'd1);
    checkOutput("t5_busy",  32'(busy),     32'd0);
    checkOutput("t5_ovf",   32'(overflow), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (tx !== 1'b1) checkOutput("t5_quiet", 32'(tx), 32'd1);
    end
    checkOutput("t5_quiet_all", 32'(tx), 32'd1);
    checkOutput("t5_rx_none", 32'(rxQ.size()), 32'd0);

    // Randomized traffic with varying write density.
    doReset();
    rxQ.delete();
    mTxLog.delete();
    for (int blk = 0; blk < 8; blk++) begin
      case (blk % 3)
        0:       pct = 5;
        1:       pct = 30;
        default: pct = 90;
      endcase
      for (int i = 0; i < 200; i++) begin
        applyStimulus(1'($urandom_range(0, 99) < pct), 8'($urandom));
      end
    end
    waitIdle(400);
    checkRx("rand_rx", mTxLog);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
